// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU divider.
//   div_state_t : control FSM states of the restoring divider
//   DIV_*       : default lane width / lane count / step-counter width
//   cnt_w()     : step-counter width for a given lane width
//   lane_lsb()  : LSB position of a lane inside a packed LANES*WIDTH vector
package vec_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DIV_WIDTH = 8;
  localparam int DIV_LANES = 4;
  localparam int DIV_CNT_W = cnt_w(DIV_WIDTH);

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/div_lane_step.sv
// One restoring-division step for a single lane (purely combinational).
//   rem      : partial remainder entering the step (always < divisor when divisor != 0)
//   dvd_bit  : next dividend bit, MSB first
//   divisor  : lane divisor
//   rem_next : partial remainder after the step
//   q_bit    : quotient bit produced by the step (1 = subtraction kept)
module div_lane_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The shifted remainder is below 2*divisor, so a non-negative difference
  // always fits in WIDTH bits and the extra MSB is exactly the borrow.
  // A zero divisor never borrows: the dividend streams into the remainder
  // and every quotient bit is 1.
  assign shifted  = {rem, dvd_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign borrow   = diff[WIDTH];
  assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_bit    = ~borrow;

endmodule

// File: rtl/vec_div_restoring.sv
// Multi-cycle unsigned restoring divider, LANES lanes in lockstep.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   dividend, divisor     : packed lane operands, lane i = [i*WIDTH +: WIDTH]
//   out_valid / out_ready : result handshake (valid only in DONE)
//   quotient, remainder   : packed lane results, held stable while in DONE
//   div_by_zero           : per-lane flag, divisor was zero
// One quotient bit per lane per cycle; BUSY lasts exactly WIDTH cycles.
module vec_div_restoring
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int LANES = DIV_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] dividend,
  input  logic [LANES*WIDTH-1:0] divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] quotient,
  output logic [LANES*WIDTH-1:0] remainder,
  output logic [LANES-1:0]       div_by_zero
);

  localparam int CNT_W = cnt_w(WIDTH);

  div_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [LANES*WIDTH-1:0] dvd_q;   // dividend shift register, MSB consumed first
  logic [LANES*WIDTH-1:0] dvs_q;
  logic [LANES*WIDTH-1:0] rem_q;
  logic [LANES*WIDTH-1:0] quo_q;
  logic [LANES-1:0]       dbz_q;
  logic [LANES*WIDTH-1:0] rem_step;
  logic [LANES-1:0]       qbit_step;
  logic [LANES-1:0]       dbz_in;
  logic                   accept;

  assign accept = in_valid && (state_q == IDLE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    div_lane_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q[lane_lsb(i, WIDTH) +: WIDTH]),
      .dvd_bit  (dvd_q[lane_lsb(i, WIDTH) + WIDTH - 1]),
      .divisor  (dvs_q[lane_lsb(i, WIDTH) +: WIDTH]),
      .rem_next (rem_step[lane_lsb(i, WIDTH) +: WIDTH]),
      .q_bit    (qbit_step[i])
    );
  end

  always_comb begin
    dbz_in = '0;
    for (int i = 0; i < LANES; i++) begin
      dbz_in[i] = (divisor[lane_lsb(i, WIDTH) +: WIDTH] == '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: next-state gets its default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)       state_d = BUSY;
      BUSY:    if (cnt_q == '0)    state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dbz_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_W'(WIDTH - 1);
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      quo_q <= '0;
      dbz_q <= dbz_in;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - 1'b1;
      rem_q <= rem_step;
      for (int i = 0; i < LANES; i++) begin
        dvd_q[lane_lsb(i, WIDTH) +: WIDTH] <= dvd_q[lane_lsb(i, WIDTH) +: WIDTH] << 1;
        quo_q[lane_lsb(i, WIDTH) +: WIDTH] <= (quo_q[lane_lsb(i, WIDTH) +: WIDTH] << 1)
                                              | WIDTH'(qbit_step[i]);
      end
    end
  end

  // Handshake outputs decode the state register only: no input-to-output path.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_vec_div_restoring.sv
// Self-checking bench for vec_div_restoring (WIDTH=8, LANES=4).
// Expected results come from plain integer / and % per lane.
module tb_vec_div_restoring;

  localparam int W = 8;
  localparam int L = 4;
  typedef logic [L*W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vec_t          dividend;
  vec_t          divisor;
  logic          out_valid;
  logic          out_ready;
  vec_t          quotient;
  vec_t          remainder;
  logic [L-1:0]  div_by_zero;

  int checks   = 0;
  int failures = 0;

  vec_div_restoring #(.WIDTH(W), .LANES(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: per-lane unsigned division; zero divisor gives all-ones quotient
  // and the dividend as remainder.
  function automatic void model(input vec_t a, input vec_t b,
                                output vec_t q, output vec_t r, output logic [L-1:0] z);
    q = '0; r = '0; z = '0;
    for (int i = 0; i < L; i++) begin
      int unsigned av, bv;
      av = a[i*W +: W];
      bv = b[i*W +: W];
      if (bv == 0) begin
        q[i*W +: W] = (1 << W) - 1;
        r[i*W +: W] = W'(av);
        z[i]        = 1'b1;
      end else begin
        q[i*W +: W] = W'(av / bv);
        r[i*W +: W] = W'(av % bv);
      end
    end
  endfunction

  function automatic vec_t rand_vec(input int unsigned zero_odds);
    vec_t v;
    for (int i = 0; i < L; i++) begin
      case ($urandom_range(3))
        0:       v[i*W +: W] = W'($urandom_range(15));
        default: v[i*W +: W] = W'($urandom);
      endcase
      if (zero_odds != 0 && $urandom_range(zero_odds - 1) == 0) v[i*W +: W] = '0;
    end
    return v;
  endfunction

  // Presents operands until accepted; outputs sampled 1 time unit after edges.
  task automatic issue(input vec_t a, input vec_t b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL issue_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // cycles = number of edges after the accepting edge until out_valid is seen.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1; cycles++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL done_timeout: out_valid=%b required 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic run_op(input vec_t a, input vec_t b, output vec_t q, output vec_t r,
                        output logic [L-1:0] z, output int cycles);
    issue(a, b);
    wait_done(cycles);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_handshake: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: q=%h r=%h z=%b required all zero", quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t a, b, q, r, eq, er;
    logic [L-1:0] z, ez;
    int cyc;
    a = {8'd200, 8'd0, 8'd255, 8'd100};
    b = {8'd200, 8'd5, 8'd1,   8'd7};
    run_op(a, b, q, r, z, cyc);
    model(a, b, eq, er, ez);
    checks++;
    if (q !== {8'd1, 8'd0, 8'd255, 8'd14} || q !== eq) begin
      failures++;
      $display("FAIL directed_q: got %h required %h", q, eq);
    end
    checks++;
    if (r !== 32'h0000_0002 || r !== er) begin
      failures++;
      $display("FAIL directed_r: got %h required %h", r, er);
    end
    checks++;
    if (z !== 4'b0000) begin
      failures++;
      $display("FAIL directed_dbz: got %b required 0000", z);
    end
    // Accepting cycle is cycle 0; out_valid must first appear in cycle W+1,
    // i.e. after W further edges.
    checks++;
    if (cyc != W) begin
      failures++;
      $display("FAIL directed_latency: out_valid in cycle %0d required %0d", cyc + 1, W + 1);
    end
  endtask

  task automatic test_div_zero();
    vec_t a, b, q, r, eq, er;
    logic [L-1:0] z, ez;
    int cyc;
    a = rand_vec(0);
    b = rand_vec(0);
    a[1*W +: W] = 8'd77;
    b[1*W +: W] = 8'd0;
    for (int i = 0; i < L; i++) if (i != 1 && b[i*W +: W] == '0) b[i*W +: W] = 8'd3;
    run_op(a, b, q, r, z, cyc);
    model(a, b, eq, er, ez);
    checks++;
    if (q !== eq || q[1*W +: W] !== 8'd255) begin
      failures++;
      $display("FAIL dbz_q: got %h required %h", q, eq);
    end
    checks++;
    if (r !== er || r[1*W +: W] !== 8'd77) begin
      failures++;
      $display("FAIL dbz_r: got %h required %h", r, er);
    end
    checks++;
    if (z !== 4'b0010) begin
      failures++;
      $display("FAIL dbz_flag: got %b required 0010", z);
    end
    checks++;
    if (cyc != W) begin
      failures++;
      $display("FAIL dbz_latency: got %0d edges required %0d", cyc, W);
    end
  endtask

  task automatic test_small_over_large();
    vec_t q, r;
    logic [L-1:0] z;
    int cyc;
    run_op({L{8'd5}}, {L{8'd9}}, q, r, z, cyc);
    checks++;
    if (q !== '0 || r !== {L{8'd5}} || z !== '0) begin
      failures++;
      $display("FAIL small_over_large: q=%h r=%h z=%b required q=0 r=05050505 z=0", q, r, z);
    end
  endtask

  task automatic test_backpressure();
    vec_t a, b, q, r, eq, er;
    logic [L-1:0] ez;
    int cyc;
    bit bad_stable;
    a = rand_vec(0);
    b = rand_vec(6);
    out_ready = 1'b0;
    issue(a, b);
    wait_done(cyc);
    q = quotient;
    r = remainder;
    model(a, b, eq, er, ez);
    checks++;
    if (q !== eq || r !== er || div_by_zero !== ez) begin
      failures++;
      $display("FAIL bp_result: q=%h r=%h z=%b required q=%h r=%h z=%b",
               q, r, div_by_zero, eq, er, ez);
    end
    bad_stable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && quotient === q && remainder === r)) begin
        failures++;
        bad_stable = 1'b1;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b q=%h r=%h required ov=1 ir=0 q=%h r=%h",
                 k, out_valid, in_ready, quotient, remainder, q, r);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_handshake_ready: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_in_valid();
    vec_t a, b, eq, er;
    logic [L-1:0] ez;
    int cyc;
    a = {8'd250, 8'd17, 8'd99, 8'd100};
    b = {8'd3,   8'd4,  8'd0,  8'd7};
    issue(a, b);
    repeat (2) begin @(posedge clk); #1; end
    dividend = {L{8'd1}};
    divisor  = {L{8'd1}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc);
    model(a, b, eq, er, ez);
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      failures++;
      $display("FAIL ignore_in_valid: q=%h r=%h z=%b required q=%h r=%h z=%b",
               quotient, remainder, div_by_zero, eq, er, ez);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    vec_t q, r;
    logic [L-1:0] z;
    int cyc;
    issue({L{8'd200}}, {L{8'd0}});
    // Now in BUSY cycle 1; advance to BUSY cycle 3 and reset there.
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {quotient, remainder, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL mid_reset: ov=%b ir=%b q=%h r=%h z=%b required ov=0 ir=1 all zero",
               out_valid, in_ready, quotient, remainder, div_by_zero);
    end
    run_op({L{8'd100}}, {L{8'd7}}, q, r, z, cyc);
    checks++;
    if (q !== {L{8'd14}} || r !== {L{8'd2}} || z !== '0 || cyc != W) begin
      failures++;
      $display("FAIL after_reset_op: q=%h r=%h z=%b edges=%0d required q=0e0e0e0e r=02020202 z=0 edges=%0d",
               q, r, z, cyc, W);
    end
  endtask

  task automatic test_random();
    vec_t a, b, q, r, eq, er;
    logic [L-1:0] z, ez;
    int cyc;
    for (int n = 0; n < 40; n++) begin
      a = rand_vec(0);
      b = rand_vec(8);
      run_op(a, b, q, r, z, cyc);
      model(a, b, eq, er, ez);
      checks++;
      if (q !== eq || r !== er || z !== ez || cyc != W) begin
        failures++;
        $display("FAIL random[%0d]: a=%h b=%h q=%h r=%h z=%b edges=%0d required q=%h r=%h z=%b edges=%0d",
                 n, a, b, q, r, z, cyc, eq, er, ez, W);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int n;
    dividend  = rand_vec(0);
    divisor   = rand_vec(0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 3 * (W + 2) + 2; c++) begin
      if (in_ready) accepts.push_back(c);
      checks++;
      if (out_valid && in_ready) begin
        failures++;
        $display("FAIL b2b_overlap[%0d]: in_ready=1 while out_valid=1 required in_ready=0", c);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (accepts.size() < 3) begin
      failures++;
      $display("FAIL b2b_accepts: got %0d accepts required at least 3", accepts.size());
    end
    for (int i = 1; i < accepts.size(); i++) begin
      checks++;
      if (accepts[i] - accepts[i-1] != W + 2) begin
        failures++;
        $display("FAIL b2b_period[%0d]: got %0d cycles required %0d",
                 i, accepts[i] - accepts[i-1], W + 2);
      end
    end
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_small_over_large();
    test_backpressure();
    test_ignore_in_valid();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
